// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the multi-channel PWM generator.
//   - DEF_* : default parameter values for pwm_multi / pwm_debounce
//   - phase()    : reset value of a channel's period counter (staggered start)
//   - sat_step() : one saturating duty step, clamped to 0..period
package pwm_pkg;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_PERIOD    = 10;
  localparam int DEF_STEP      = 1;
  localparam int DEF_DUTY_INIT = 5;
  localparam int DEF_DEBOUNCE  = 4;

  // Spreads the channels' rising edges evenly across one period.
  function automatic int phase(input int i, input int period, input int channels);
    return (i * period) / channels;
  endfunction

  // Arithmetic is done in 32-bit int, which is wider than CNT_W+1, so the
  // decrement cannot wrap below zero and the increment cannot overflow.
  // Simultaneous inc and dec cancel out.
  function automatic int sat_step(input int duty, input int step, input int period,
                                  input logic inc, input logic dec);
    int r;
    r = duty;
    if (inc && !dec) begin
      r = (duty + step > period) ? period : duty + step;
    end else if (dec && !inc) begin
      r = (duty < step) ? 0 : duty - step;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_debounce.sv
// pwm_debounce: 2-flop synchroniser, debounce counter and press detector for
// one asynchronous push-button.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_i   : raw button level, asynchronous to clk
//   press_o : one-cycle pulse on each 0->1 edge of the debounced level
module pwm_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [DW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreeing cycle restarts it, so the level flips on the
  // DEBOUNCE-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DW'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with per-channel push-button duty
// control. Each channel has its own period counter (phase-staggered at reset),
// a target duty adjusted by debounced presses, and an active duty copied from
// the target only at the end of a period so the output never glitches.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   swt_increase : per-channel increase buttons (bit i -> channel i), async
//   swt_decrease : per-channel decrease buttons, async
//   PWM_OUT      : registered PWM outputs, one per channel
//   duty_out     : active duty per channel, channel i at [i*CNT_W +: CNT_W]
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int STEP      = DEF_STEP,
  parameter int DUTY_INIT = DEF_DUTY_INIT,
  parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       swt_increase,
  input  logic [CHANNELS-1:0]       swt_decrease,
  output logic [CHANNELS-1:0]       PWM_OUT,
  output logic [CHANNELS*CNT_W-1:0] duty_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] INIT = CNT_W'(DUTY_INIT);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CNT_W-1:0] PHASE = CNT_W'(phase(i, PERIOD, CHANNELS));

    logic             inc_press, dec_press;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             pwm_q;

    pwm_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (swt_increase[i]),
      .press_o (inc_press)
    );

    pwm_debounce #(.DEBOUNCE(DEBOUNCE)) u_dec (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (swt_decrease[i]),
      .press_o (dec_press)
    );

    always_comb begin
      cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      target_d = CNT_W'(sat_step(int'(target_q), STEP, PERIOD, inc_press, dec_press));
      // Shadow load at the period boundary only.
      active_d = (cnt_q == LAST) ? target_q : active_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= PHASE;
        target_q <= INIT;
        active_q <= INIT;
        pwm_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        target_q <= target_d;
        active_q <= active_d;
        // active_q == PERIOD keeps this true for every cnt value, so the
        // output stays high across the wrap.
        pwm_q    <= (cnt_q < active_q);
      end
    end

    assign PWM_OUT[i]                 = pwm_q;
    assign duty_out[i*CNT_W +: CNT_W] = active_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed test of pwm_multi with CHANNELS=2, PERIOD=10, STEP=1, DUTY_INIT=5,
// DEBOUNCE=4. Each expected duty_out value is queued when a press is issued;
// a monitor pops and compares whenever duty_out changes.
module tb_pwm_multi;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int P  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     inc = '0;
  logic [CH-1:0]     dec = '0;
  logic [CH-1:0]     pwm;
  logic [CH*W-1:0]   duty;

  int                errors = 0;
  int                checks = 0;
  logic [CH*W-1:0]   exp_q[$];
  int                model[CH];
  logic [CH*W-1:0]   last_duty;
  bit                mon_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  pwm_multi #(
    .CHANNELS(CH), .CNT_W(W), .PERIOD(P), .STEP(1), .DUTY_INIT(5), .DEBOUNCE(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .swt_increase (inc),
    .swt_decrease (dec),
    .PWM_OUT      (pwm),
    .duty_out     (duty)
  );

  function automatic logic [CH*W-1:0] pack_model();
    return {W'(model[1]), W'(model[0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // queue the new expected duty_out whenever the model's active value changes
  task automatic set_model(input int ch, input int v);
    if (v != model[ch]) begin
      model[ch] = v;
      exp_q.push_back(pack_model());
    end
  endtask

  // leaves the bench at the negedge right after release (cnt0 == 0)
  task automatic apply_reset();
    @(negedge clk);
    inc = '0;
    dec = '0;
    set_model(0, 5);
    set_model(1, 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int ch, input bit up, input int hold, input int gap);
    int v;
    if (up) begin
      inc[ch] = 1'b1;
      v = (model[ch] + 1 > P) ? P : model[ch] + 1;
    end else begin
      dec[ch] = 1'b1;
      v = (model[ch] == 0) ? 0 : model[ch] - 1;
    end
    set_model(ch, v);
    repeat (hold) @(negedge clk);
    inc[ch] = 1'b0;
    dec[ch] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pwm[ch]) hi++;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && duty !== last_duty) begin
      last_duty = duty;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL duty_unexpected: got %h expected no change", duty);
      end else begin
        chk("duty_out", 32'(duty), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin : stim
    int hi;
    model[0] = 5;
    model[1] = 5;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_pwm", 32'(pwm), 0);
    chk("reset_duty", 32'(duty), 32'({8'd5, 8'd5}));
    last_duty = duty;
    mon_en = 1'b1;

    // free-running waveform: ch0 phase 0, ch1 phase 5
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("wave_ch0", 32'(pwm[0]), 32'(((k - 1) % P) < 5));
      chk("wave_ch1", 32'(pwm[1]), 32'(((k + 4) % P) < 5));
    end

    // increase x3 with boundary timing of the first load
    apply_reset();
    inc[0] = 1'b1;
    set_model(0, 6);
    repeat (9) @(negedge clk);
    chk("load_before_boundary", 32'(duty[W-1:0]), 5);
    @(negedge clk);
    chk("load_at_boundary", 32'(duty[W-1:0]), 6);
    inc[0] = 1'b0;
    repeat (10) @(negedge clk);
    press(0, 1'b1, 10, 10);
    press(0, 1'b1, 10, 10);
    repeat (20) @(negedge clk);
    count_high(0, P, hi);
    chk("duty8_high_count", 32'(hi), 8);
    count_high(1, P, hi);
    chk("ch1_untouched_count", 32'(hi), 5);

    // decrease saturates at 0
    apply_reset();
    for (int k = 0; k < 7; k++) press(0, 1'b0, 10, 10);
    repeat (20) @(negedge clk);
    count_high(0, 2 * P, hi);
    chk("duty0_high_count", 32'(hi), 0);
    chk("duty0_value", 32'(duty[W-1:0]), 0);

    // increase saturates at PERIOD, no low cycle at the wrap
    apply_reset();
    for (int k = 0; k < 7; k++) press(0, 1'b1, 10, 10);
    repeat (20) @(negedge clk);
    count_high(0, 2 * P, hi);
    chk("duty10_high_count", 32'(hi), 20);
    chk("duty10_value", 32'(duty[W-1:0]), 10);

    // simultaneous inc and dec cancel
    apply_reset();
    inc[0] = 1'b1;
    dec[0] = 1'b1;
    repeat (10) @(negedge clk);
    inc[0] = 1'b0;
    dec[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("both_pressed", 32'(duty), 32'({8'd5, 8'd5}));

    // 3-cycle glitch is filtered
    inc[1] = 1'b1;
    repeat (3) @(negedge clk);
    inc[1] = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_ch1", 32'(duty[2*W-1:W]), 5);

    // press accepted, reset before the boundary discards it
    apply_reset();
    inc[0] = 1'b1;
    repeat (9) @(negedge clk);
    inc[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset_pwm", 32'(pwm), 0);
    chk("midreset_duty", 32'(duty), 32'({8'd5, 8'd5}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("after_midreset_duty", 32'(duty), 32'({8'd5, 8'd5}));

    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator with per-channel increase/decrease push-button duty control, input debouncing, glitch-free duty updates and phase-staggered channels. Each channel keeps its own duty register, adjusted in fixed steps and saturated at 0 and PERIOD. The new duty value takes effect only at that channel's period boundary. The block sits between the board push-button inputs and the PWM output pins, and replaces the single-channel fixed-10%-step generator.

## Interface
- CHANNELS, 4, number of independent PWM channels (1..16)
- CNT_W, 8, width of the period counter and duty registers; must satisfy PERIOD < 2^CNT_W
- PERIOD, 10, PWM period in clk cycles (>= 2)
- STEP, 1, duty increment/decrement per qualified button press (1..PERIOD)
- DUTY_INIT, 5, duty value after reset (0..PERIOD)
- DEBOUNCE, 4, number of consecutive stable cycles needed to accept a button level (>= 1)
- clk  in  1  system clock (100 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- swt_increase  in  CHANNELS  per-channel increase button; bit i belongs to channel i; asynchronous to clk
- swt_decrease  in  CHANNELS  per-channel decrease button; asynchronous to clk
- PWM_OUT  out  CHANNELS  registered PWM outputs
- duty_out  out  CHANNELS*CNT_W  active duty of each channel, channel i at bits [i*CNT_W +: CNT_W]

## Operation
- Each button bit passes through a 2-flop synchroniser and then a debouncer. The debounced level changes only after the synchronised input holds the new level for DEBOUNCE consecutive cycles.
- A press is the 0->1 edge of a debounced level. Each press produces exactly one step, however long the button is held.
- Per channel, on each cycle:
  - inc press only: duty_target <= min(duty_target + STEP, PERIOD).
  - dec press only: duty_target <= max(duty_target - STEP, 0). Compute with no unsigned underflow; use a CNT_W+1-bit intermediate.
  - both presses in the same cycle: duty_target unchanged.
  - A press of one button while the other is held but already debounced counts as a single press and is applied.
- Period counter per channel: cnt_i runs 0..PERIOD-1 and wraps to 0.
  - Reset value of cnt_i is (i*PERIOD)/CHANNELS, using integer division. This spreads the channels' rising edges across the period.
- Shadow load: in the cycle where cnt_i == PERIOD-1, duty_active_i <= duty_target_i. duty_active_i changes at no other time.
- Output: PWM_OUT_i <= (cnt_i < duty_active_i).
  - duty_active = 0 gives a constant low output.
  - duty_active = PERIOD gives a constant high output with no glitch across the wrap.
- duty_out reflects duty_active, not duty_target.
- Channels are fully independent; a press on one channel has no effect on any other channel.

## Timing
- Reset values:
  - PWM_OUT = 0.
  - duty_target = duty_active = DUTY_INIT; duty_out = DUTY_INIT on every channel.
  - cnt_i = phase_i.
  - Synchronisers and debouncers = 0.
- Button-to-target latency: 2 sync cycles + DEBOUNCE cycles + 1 edge-detect cycle + 1 register cycle. With DEBOUNCE=4 this is 8 cycles from the input edge to the duty_target update.
- Target-to-output latency: up to PERIOD cycles, waiting for the next cnt_i == PERIOD-1. The first PWM_OUT sample using the new duty follows cnt_i == 0.
- PWM_OUT lags cnt by 1 cycle. The first valid output is 1 cycle after reset release.
- Bounce: a pulse shorter than DEBOUNCE cycles produces no step.
- If rst asserts mid-period or mid-debounce, every state returns to its reset value immediately. Pending presses are discarded.
- Several presses within one period accumulate in duty_target. Only the final value is loaded at the boundary.

## Structure
- Shared package pwm_pkg, containing:
  - the default parameter constants;
  - a phase-offset function phase(i, PERIOD, CHANNELS);
  - a saturating add/sub function for duty values.
- Sub-module pwm_debounce, containing the synchroniser, debounce counter and rising-edge pulse output. It is parameterised by DEBOUNCE and instantiated 2*CHANNELS times.
- Top-level pwm_multi contains a generate loop over the channels. Each iteration holds cnt, duty_target, duty_active and the output register.

## Test plan
Parameters for all scenarios: CHANNELS=2, PERIOD=10, STEP=1, DUTY_INIT=5, DEBOUNCE=4.
- Reset, no presses:
  - ch0 PWM_OUT is high for 5 cycles, low for 5, repeating; duty_out=5.
  - ch1 shows the same waveform shifted by 5 cycles.
- swt_increase[0] held for 10 cycles, three times, with 10-cycle gaps:
  - duty_out[0] goes 6, 7, 8, each change at a period boundary.
  - ch1 is unchanged.
- swt_decrease[0] held for 10 cycles, repeated 7 times from duty 5:
  - duty saturates at 0 and PWM_OUT[0] stays low.
  - Repeat with increase from 5 to saturate at 10: PWM_OUT[0] stays high, with no low cycle at the wrap.
- Increase and decrease pulses rising in the same cycle on ch0:
  - duty unchanged at 5.
- 3-cycle glitch on swt_increase[1]:
  - no change, duty_out[1]=5.
- Press accepted, then rst asserted before the period boundary:
  - all outputs return to reset values at once; duty_out=5 after release.
